// File: rtl/fetch_btb_unit.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit taken counters; repairs D-stage mispredictions.
// Optional BTB_STATS_EN adds saturating branch / mispredict statistics outputs.
module fetch_btb_unit #(
    parameter int unsigned     PC_W        = 32,
    parameter int unsigned     BTB_ENTRIES = 8,
    parameter int unsigned     IMEM_AW     = 7,
    parameter logic [PC_W-1:0] RESET_PC    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_f,
    input  logic               branch_valid_d,
    input  logic               pc_src_d,
    input  logic [PC_W-1:0]    branch_target_d,
    input  logic [PC_W-1:0]    pc_d,
    input  logic               pred_taken_d,
    input  logic [PC_W-1:0]    pred_target_d,
    output logic [PC_W-1:0]    pc_f,
    output logic [PC_W-1:0]    pc_plus4_f,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               predict_taken_f,
    output logic [PC_W-1:0]    predict_target_f,
    output logic               mispredict_d
`ifdef BTB_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    localparam int unsigned     IDX_W = $clog2(BTB_ENTRIES);
    localparam int unsigned     TAG_W = PC_W - IDX_W - 2;
    localparam logic [PC_W-1:0] FOUR  = PC_W'(4);

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [PC_W-1:0]        btb_target [BTB_ENTRIES];
    logic [1:0]             btb_ctr    [BTB_ENTRIES];

    logic [IDX_W-1:0] idx_f;
    logic [TAG_W-1:0] tag_f;
    logic             hit_f;
    logic [IDX_W-1:0] idx_d;
    logic [TAG_W-1:0] tag_d;
    logic             hit_d;

    logic             dir_wrong;
    logic             tgt_wrong;
    logic [PC_W-1:0]  redirect_pc;
    logic [PC_W-1:0]  pc_next;

    // Fetch-side lookup
    always_comb begin
        idx_f = pc_f[IDX_W+1:2];
        tag_f = pc_f[PC_W-1:IDX_W+2];
        hit_f = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
    end

    assign predict_taken_f  = hit_f & btb_ctr[idx_f][1];
    assign predict_target_f = hit_f ? btb_target[idx_f] : '0;
    assign pc_plus4_f       = pc_f + FOUR;
    assign imem_addr        = pc_f[IMEM_AW+1:2];

    // Resolve-side lookup, used for the update decision
    always_comb begin
        idx_d = pc_d[IDX_W+1:2];
        tag_d = pc_d[PC_W-1:IDX_W+2];
        hit_d = btb_valid[idx_d] && (btb_tag[idx_d] == tag_d);
    end

    always_comb begin
        dir_wrong    = pred_taken_d ^ pc_src_d;
        tgt_wrong    = pred_taken_d & pc_src_d & (pred_target_d != branch_target_d);
        mispredict_d = branch_valid_d & (dir_wrong | tgt_wrong);
        redirect_pc  = (pred_taken_d & ~pc_src_d) ? (pc_d + FOUR) : branch_target_d;
    end

    // A redirect wins over a stall so the wrong-path fetch is never held
    always_comb begin
        pc_next = pc_plus4_f;
        if (mispredict_d) begin
            pc_next = redirect_pc;
        end else if (stall_f) begin
            pc_next = pc_f;
        end else if (predict_taken_f) begin
            pc_next = predict_target_f;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f <= RESET_PC;
        end else begin
            pc_f <= pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= 2'b01;
            end
        end else if (branch_valid_d) begin
            if (pc_src_d) begin
                btb_target[idx_d] <= branch_target_d;
                if (hit_d) begin
                    btb_ctr[idx_d] <= (btb_ctr[idx_d] == 2'b11) ? 2'b11 : btb_ctr[idx_d] + 2'd1;
                end else begin
                    // Allocation silently evicts whatever aliased into this slot
                    btb_valid[idx_d] <= 1'b1;
                    btb_tag[idx_d]   <= tag_d;
                    btb_ctr[idx_d]   <= 2'b10;
                end
            end else if (hit_d) begin
                btb_ctr[idx_d] <= (btb_ctr[idx_d] == 2'b00) ? 2'b00 : btb_ctr[idx_d] - 2'd1;
            end
        end
    end

`ifdef BTB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (branch_valid_d && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict_d && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_btb_unit.sv
// Scoreboard bench for fetch_btb_unit: directed scenarios followed by random branch traffic,
// checked against a behavioural BTB model. Stats outputs are checked when BTB_STATS_EN is defined.
module tb_fetch_btb_unit;

    localparam int unsigned N     = 8;
    localparam int unsigned IDX_W = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        branch_valid_d;
    logic        pc_src_d;
    logic [31:0] branch_target_d;
    logic [31:0] pc_d;
    logic        pred_taken_d;
    logic [31:0] pred_target_d;
    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [6:0]  imem_addr;
    logic        predict_taken_f;
    logic [31:0] predict_target_f;
    logic        mispredict_d;
`ifdef BTB_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    fetch_btb_unit #(.PC_W(32), .BTB_ENTRIES(N), .IMEM_AW(7), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_f          (stall_f),
        .branch_valid_d   (branch_valid_d),
        .pc_src_d         (pc_src_d),
        .branch_target_d  (branch_target_d),
        .pc_d             (pc_d),
        .pred_taken_d     (pred_taken_d),
        .pred_target_d    (pred_target_d),
        .pc_f             (pc_f),
        .pc_plus4_f       (pc_plus4_f),
        .imem_addr        (imem_addr),
        .predict_taken_f  (predict_taken_f),
        .predict_target_f (predict_target_f),
        .mispredict_d     (mispredict_d)
`ifdef BTB_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] addr;
        logic        pt;
        logic [31:0] ptgt;
        logic        misp;
        logic [31:0] nbr;
        logic [31:0] nmis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit [31:0] m_pc;
    bit        m_valid [N];
    bit [31:0] m_tag   [N];
    bit [31:0] m_tgt   [N];
    int        m_ctr   [N];
    bit [31:0] m_nbr;
    bit [31:0] m_nmis;

    task automatic model_reset();
        m_pc = 32'h0;
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 1;
        end
        m_nbr  = 0;
        m_nmis = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One cycle: drive inputs, predict outputs, push expectation, advance the model
    task automatic step(input bit r, input bit st, input bit bv, input bit src,
                        input bit [31:0] tgt, input bit [31:0] pcd,
                        input bit pt, input bit [31:0] ptgt);
        exp_t      e;
        int        fi, di;
        bit        fhit, dhit;
        bit [31:0] redirect;
        rst             = r;
        stall_f         = st;
        branch_valid_d  = bv;
        pc_src_d        = src;
        branch_target_d = tgt;
        pc_d            = pcd;
        pred_taken_d    = pt;
        pred_target_d   = ptgt;

        fi     = int'((m_pc >> 2) % N);
        fhit   = m_valid[fi] && (m_tag[fi] == (m_pc >> (IDX_W + 2)));
        e.pc   = m_pc;
        e.pc4  = m_pc + 4;
        e.addr = (m_pc >> 2) % 128;
        e.pt   = fhit && (m_ctr[fi] >= 2);
        e.ptgt = fhit ? m_tgt[fi] : 32'h0;
        e.misp = bv && ((pt != src) || (pt && src && (ptgt != tgt)));
        e.nbr  = m_nbr;
        e.nmis = m_nmis;
        sb.push_back(e);

        redirect = (pt && !src) ? pcd + 4 : tgt;
        if (r) begin
            model_reset();
        end else begin
            if (e.misp)      m_pc = redirect;
            else if (st)     m_pc = m_pc;
            else if (e.pt)   m_pc = e.ptgt;
            else             m_pc = m_pc + 4;
            if (bv) begin
                di   = int'((pcd >> 2) % N);
                dhit = m_valid[di] && (m_tag[di] == (pcd >> (IDX_W + 2)));
                if (src && dhit) begin
                    m_tgt[di] = tgt;
                    m_ctr[di] = (m_ctr[di] < 3) ? m_ctr[di] + 1 : 3;
                end else if (src) begin
                    m_valid[di] = 1;
                    m_tag[di]   = pcd >> (IDX_W + 2);
                    m_tgt[di]   = tgt;
                    m_ctr[di]   = 2;
                end else if (dhit) begin
                    m_ctr[di] = (m_ctr[di] > 0) ? m_ctr[di] - 1 : 0;
                end
                if (m_nbr != 32'hFFFF_FFFF) m_nbr = m_nbr + 1;
            end
            if (e.misp && m_nmis != 32'hFFFF_FFFF) m_nmis = m_nmis + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit st);
        step(0, st, 0, 0, 0, 0, 0, 0);
    endtask

    // Steer fetch to a PC by resolving a predicted-taken branch at pc-4 as not taken
    task automatic goto(input bit [31:0] pc);
        step(0, 0, 1, 0, 0, pc - 4, 1, 0);
    endtask

    // Monitor: compares the DUT against the oldest expectation each mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc_f",             pc_f,                    e.pc);
                chk("pc_plus4_f",       pc_plus4_f,              e.pc4);
                chk("imem_addr",        {25'h0, imem_addr},      e.addr);
                chk("predict_taken_f",  {31'h0, predict_taken_f}, {31'h0, e.pt});
                chk("predict_target_f", predict_target_f,        e.ptgt);
                chk("mispredict_d",     {31'h0, mispredict_d},   {31'h0, e.misp});
`ifdef BTB_STATS_EN
                chk("stat_branches",    stat_branches,           e.nbr);
                chk("stat_mispredicts", stat_mispredicts,        e.nmis);
`endif
            end
        end
    end

    initial begin
        bit        r, st, bv, src, pt;
        bit [31:0] tgt, pcd, ptgt;
        rst = 1; stall_f = 0; branch_valid_d = 0; pc_src_d = 0;
        branch_target_d = 0; pc_d = 0; pred_taken_d = 0; pred_target_d = 0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset and sequential fetch
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) idle(0);
        // Cold taken branch allocates entry 4
        step(0, 0, 1, 1, 32'h40, 32'h10, 0, 0);
        idle(0);
        // Warm hit, then matching resolve strengthens to 2'b11
        goto(32'h10);
        step(0, 0, 1, 1, 32'h40, 32'h10, 1, 32'h40);
        // Hysteresis: two not-taken resolves, then fetch predicts not taken
        step(0, 0, 1, 0, 0, 32'h10, 1, 32'h40);
        step(0, 0, 1, 0, 0, 32'h10, 0, 0);
        goto(32'h10);
        idle(0);
        // Target change, then alias at 0x30 evicts 0x10
        step(0, 0, 1, 1, 32'h40, 32'h10, 0, 0);
        step(0, 0, 1, 1, 32'h80, 32'h10, 1, 32'h40);
        goto(32'h10);
        idle(0);
        step(0, 0, 1, 1, 32'h90, 32'h30, 0, 0);
        goto(32'h10);
        idle(0);
        // Stall holds; redirect overrides stall
        idle(1);
        idle(1);
        step(0, 1, 1, 1, 32'h60, 32'h24, 0, 0);
        idle(0);
        // Reset during a branch cycle must not write the BTB
        step(1, 0, 1, 1, 32'hA0, 32'h50, 0, 0);
        goto(32'h50);
        idle(0);
        // PC wrap-around
        step(0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0C, 0, 0);
        idle(0);
        step(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 1, 32'h8);
        idle(0);

        // Randomised traffic over a small PC window to exercise hits and aliasing
        for (int i = 0; i < 1500; i++) begin
            r    = ($urandom_range(0, 99) == 0);
            st   = ($urandom_range(0, 3) == 0);
            bv   = ($urandom_range(0, 2) == 0);
            src  = $urandom_range(0, 1);
            tgt  = 32'($urandom_range(0, 31)) << 2;
            pcd  = 32'($urandom_range(0, 31)) << 2;
            pt   = $urandom_range(0, 1);
            ptgt = $urandom_range(0, 1) ? tgt : (32'($urandom_range(0, 31)) << 2);
            step(r, st, bv, src, tgt, pcd, pt, ptgt);
        end

        // Final reset clears counters and state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);
        idle(0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
